// File: rtl/piso_tx_if.sv
// piso_tx_if -- parallel-load / serial-out transmitter bus.
//
// Groups the word-side handshake and the serial-side status of piso_tx.
//   D     : parallel data word to transmit (N bits)
//   LOAD  : request to load D, sampled only while READY=1
//   EN    : transmit enable; 0 freezes the frame in progress
//   READY : transmitter idle and able to accept LOAD
//   SDO   : serial data out, idles high
//   BUSY  : frame in progress (inverse of READY)
//   DONE  : one-cycle pulse after a frame completes
// master : the side that supplies words (drives D/LOAD/EN)
// slave  : the transmitter itself
interface piso_tx_if #(
  parameter int N = 8
);
  logic [N-1:0] D;
  logic         LOAD;
  logic         EN;
  logic         READY;
  logic         SDO;
  logic         BUSY;
  logic         DONE;

  modport master (output D, LOAD, EN, input READY, SDO, BUSY, DONE);
  modport slave  (input D, LOAD, EN, output READY, SDO, BUSY, DONE);
endinterface

// File: rtl/piso_tx.sv
// piso_tx -- UART-style parallel-in / serial-out transmitter.
//
// Sends one start bit (0), N data bits LSB first, and one stop bit (1).
// Every bit is held on SDO for DIV enabled clock cycles; EN=0 freezes the
// frame exactly where it is. All outputs come straight from flops.
//
// Ports:
//   CLK   : single clock, rising edge active
//   Reset : asynchronous, active-high reset; aborts any frame in progress
//   bus   : piso_tx_if.slave (D, LOAD, EN in; READY, SDO, BUSY, DONE out)
// Parameters:
//   N   : data word width in bits (N >= 2)
//   DIV : clock cycles per serial bit (DIV >= 1)
module piso_tx #(
  parameter int N   = 8,
  parameter int DIV = 4
) (
  input  logic     CLK,
  input  logic     Reset,
  piso_tx_if.slave bus
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [IW-1:0]  r_idx;
  logic [N-1:0]   r_shift;
  logic           r_sdo;
  logic           r_ready;
  logic           r_busy;
  logic           r_done;

  state_t         w_state_nxt;
  logic [CW-1:0]  w_cnt_nxt;
  logic [IW-1:0]  w_idx_nxt;
  logic [N-1:0]   w_shift_nxt;
  logic           w_sdo_nxt;
  logic           w_done_nxt;
  logic           w_bit_end;

  // Last enabled cycle of the current bit time.
  assign w_bit_end = bus.EN && (r_cnt == CW'(DIV - 1));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_sdo   <= 1'b1;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_sdo   <= w_sdo_nxt;
      r_ready <= (w_state_nxt == S_IDLE);
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= w_done_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path through
    // the block leaves it unassigned (which would infer a latch).
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_done_nxt  = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        // EN does not gate acceptance; it only paces the frame.
        if (bus.LOAD) begin
          w_state_nxt = S_START;
          w_shift_nxt = bus.D;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_DATA;
        end else if (bus.EN) begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          // Bit 0 of the shift register is always the bit on the wire.
          w_shift_nxt = {1'b0, r_shift[N-1:1]};
          if (r_idx == IW'(N - 1)) begin
            w_state_nxt = S_STOP;
          end else begin
            w_idx_nxt = r_idx + IW'(1);
          end
        end else if (bus.EN) begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else if (bus.EN) begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // SDO is computed from the next state so it can be registered and still
    // line up with the state it describes.
    unique case (w_state_nxt)
      S_START: w_sdo_nxt = 1'b0;
      S_DATA:  w_sdo_nxt = w_shift_nxt[0];
      default: w_sdo_nxt = 1'b1;
    endcase
  end

  assign bus.SDO   = r_sdo;
  assign bus.READY = r_ready;
  assign bus.BUSY  = r_busy;
  assign bus.DONE  = r_done;

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx -- directed self-checking bench for piso_tx.
// u_dut uses N=8, DIV=4; u_dut1 uses N=8, DIV=1 for the single-cycle-bit case.
module tb_piso_tx;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  piso_tx_if #(.N(8)) bus0 ();
  piso_tx_if #(.N(8)) bus1 ();

  piso_tx #(.N(8), .DIV(4)) u_dut  (.CLK(clk), .Reset(rst), .bus(bus0));
  piso_tx #(.N(8), .DIV(1)) u_dut1 (.CLK(clk), .Reset(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance one clock; sample point is 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends word d on u_dut starting from an idle sample point and returns at
  // the sample point of the DONE cycle. Cycle 0 is the sample right after the
  // accepting edge. Optional: keep LOAD high and switch D to d_after after
  // acceptance; drop EN for stall_len edges after sample stall_at; raise LOAD
  // for 3 cycles starting at sample mid_load_at.
  task automatic run_frame(input string tag, input logic [7:0] d,
                           input bit hold_load, input logic [7:0] d_after,
                           input int stall_at, input int stall_len,
                           input int mid_load_at);
    logic bits [10];
    int   miss;
    int   done_seen;
    int   busy_bad;
    int   total;
    int   idx;

    bits[0] = 1'b0;
    for (int b = 1; b <= 8; b++) bits[b] = d[b-1];
    bits[9] = 1'b1;
    miss      = 0;
    done_seen = 0;
    busy_bad  = 0;
    total     = 40 + stall_len;

    bus0.D    = d;
    bus0.LOAD = 1'b1;
    bus0.EN   = 1'b1;
    step();
    if (!hold_load) bus0.LOAD = 1'b0;
    bus0.D = d_after;

    for (int c = 0; c < total; c++) begin
      if (stall_len > 0 && c > stall_at && c <= stall_at + stall_len)
        idx = stall_at;
      else if (stall_len > 0 && c > stall_at + stall_len)
        idx = c - stall_len;
      else
        idx = c;
      if (bus0.SDO !== bits[idx/4]) miss++;
      if (bus0.DONE !== 1'b0) done_seen++;
      if (bus0.BUSY !== 1'b1 || bus0.READY !== 1'b0) busy_bad++;
      bus0.EN = !(stall_len > 0 && c >= stall_at && c < stall_at + stall_len);
      if (mid_load_at >= 0) begin
        if (c == mid_load_at)     bus0.LOAD = 1'b1;
        if (c == mid_load_at + 3) bus0.LOAD = 1'b0;
      end
      step();
    end
    bus0.EN = 1'b1;

    check({tag, " sdo bad cycles"}, miss, 0);
    check({tag, " early done"}, done_seen, 0);
    check({tag, " busy/ready bad cycles"}, busy_bad, 0);
    check({tag, " done at end"}, bus0.DONE, 1);
    check({tag, " ready with done"}, bus0.READY, 1);
    check({tag, " busy with done"}, bus0.BUSY, 0);
  endtask

  initial begin
    logic [9:0] obs;
    int         cnt;

    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus0.D    = 8'hA5;
    bus0.LOAD = 1'b1;   // must be ignored while reset is asserted
    bus0.EN   = 1'b1;
    bus1.D    = '0;
    bus1.LOAD = 1'b0;
    bus1.EN   = 1'b1;

    // Reset state, with LOAD high across edges during reset.
    repeat (2) step();
    check("reset sdo",   bus0.SDO,   1);
    check("reset ready", bus0.READY, 1);
    check("reset busy",  bus0.BUSY,  0);
    check("reset done",  bus0.DONE,  0);
    check("reset sdo div1", bus1.SDO, 1);
    bus0.LOAD = 1'b0;
    rst = 1'b0;
    step();
    check("idle after reset ready", bus0.READY, 1);

    // Single frame 0xA5.
    run_frame("A5", 8'hA5, 1'b0, 8'h00, -1, 0, -1);
    step();
    check("A5 done one cycle", bus0.DONE, 0);

    // Back-to-back 0x01 then 0xFF with LOAD held high; D switches to 0xFF
    // right after the first acceptance, which must not disturb frame 1.
    run_frame("b2b 01", 8'h01, 1'b1, 8'hFF, -1, 0, -1);
    run_frame("b2b FF", 8'hFF, 1'b0, 8'hFF, -1, 0, -1);
    step();
    check("b2b done one cycle", bus0.DONE, 0);

    // Enable stall of 7 cycles inside data bit 3 (cycles 16..19) of 0x3C.
    run_frame("stall 3C", 8'h3C, 1'b0, 8'h3C, 17, 7, -1);
    step();
    check("stall done one cycle", bus0.DONE, 0);

    // LOAD with D=0x00 mid-frame is ignored.
    run_frame("busy load 55", 8'h55, 1'b0, 8'h00, -1, 0, 12);
    step();
    check("busy load done one cycle", bus0.DONE, 0);

    // Asynchronous reset between edges during the data phase.
    bus0.D    = 8'hA5;
    bus0.LOAD = 1'b1;
    step();
    bus0.LOAD = 1'b0;
    repeat (12) step();
    check("pre-reset busy", bus0.BUSY, 1);
    #2 rst = 1'b1;
    #1;
    check("async rst sdo",   bus0.SDO,   1);
    check("async rst ready", bus0.READY, 1);
    check("async rst busy",  bus0.BUSY,  0);
    check("async rst done",  bus0.DONE,  0);
    #1 rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 45; i++) begin
      step();
      if (bus0.DONE !== 1'b0 || bus0.READY !== 1'b1) cnt++;
    end
    check("post-reset idle no done", cnt, 0);
    run_frame("after rst C3", 8'hC3, 1'b0, 8'hC3, -1, 0, -1);
    step();

    // DIV=1: 0x80 gives SDO 0,0,0,0,0,0,0,0,1,1 over 10 cycles.
    bus1.D    = 8'h80;
    bus1.LOAD = 1'b1;
    step();
    bus1.LOAD = 1'b0;
    obs = '0;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      obs[c] = bus1.SDO;
      if (bus1.DONE !== 1'b0) cnt++;
      step();
    end
    check("div1 sdo sequence", obs, 32'h300);
    check("div1 early done", cnt, 0);
    check("div1 done", bus1.DONE, 1);
    check("div1 ready", bus1.READY, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
